// File: rtl/trade_pkg.sv
// Shared definitions for the order-entry path: session states, tally width
// and the order payload width agreed with the matching engine.
package trade_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_SEND   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam int                 COUNT_W     = 8;
  localparam logic [COUNT_W-1:0] COUNT_MAX   = 8'd255;
  localparam int                 ORDER_W_DEF = 32;

endpackage

// File: rtl/order_arbiter_rr_pick.sv
// Combinational round-robin picker: the search starts one past last_grant
// and wraps, so the most recently served source has the lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   last_grant,
  output logic [SRC_W-1:0]   winner,
  output logic               found
);

  int              idx;
  logic [SRC_W-1:0] pos;

  // Walk the sources in rotated order and keep the first requester seen
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    pos    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      pos = SRC_W'(idx);
      if (!found && req[pos]) begin
        found  = 1'b1;
        winner = pos;
      end
    end
  end

endmodule

// File: rtl/order_arbiter.sv
// Session sequencer and round-robin arbiter feeding the single matching
// engine port. Holds one order at a time and keeps saturating per-source
// tallies of orders the engine accepted.
module order_arbiter
  import trade_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ORDER_W = ORDER_W_DEF,
  parameter int SRC_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       session_start,
  input  logic                       halt_in,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ORDER_W-1:0] req_order,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       eng_valid,
  output logic [ORDER_W-1:0]         eng_order,
  output logic [SRC_W-1:0]           eng_src,
  input  logic                       eng_ready,
  output logic                       enable_count,
  output logic [NUM_REQ*COUNT_W-1:0] accepted_count,
  output logic [1:0]                 state
);

  state_t             cur_st;
  state_t             nxt_st;
  logic [SRC_W-1:0]   last_grant;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_found;
  logic               grant;
  logic               handshake;
  logic [COUNT_W-1:0] cnt [NUM_REQ];

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_MAX) ? v : v + 1'b1;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (pick_idx),
    .found      (pick_found)
  );

  // Halt beats any pending request; reset suppresses the accept strobe
  assign grant     = (cur_st == ST_ARB) && !halt_in && pick_found && !reset;
  assign handshake = (cur_st == ST_SEND) && eng_ready;
  assign state     = cur_st;

  // State register
  always_ff @(posedge clk) begin
    if (reset) cur_st <= ST_IDLE;
    else       cur_st <= nxt_st;
  end

  // Next-state logic; HALTED is absorbing until reset
  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      ST_IDLE: if (session_start) nxt_st = ST_ARB;
      ST_ARB: begin
        if (halt_in)         nxt_st = ST_HALTED;
        else if (pick_found) nxt_st = ST_SEND;
      end
      ST_SEND: if (eng_ready) nxt_st = halt_in ? ST_HALTED : ST_ARB;
      default: nxt_st = ST_HALTED;
    endcase
  end

  // Output logic: one-hot accept strobe to the winner, only during ARB
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[pick_idx] = 1'b1;
  end

  // Engine-side holding register and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_valid    <= 1'b0;
      eng_order    <= '0;
      eng_src      <= '0;
      last_grant   <= SRC_W'(NUM_REQ - 1);
      enable_count <= 1'b0;
    end else begin
      if (grant) begin
        eng_valid <= 1'b1;
        eng_order <= req_order[int'(pick_idx)*ORDER_W +: ORDER_W];
        eng_src   <= pick_idx;
      end else if (handshake) begin
        eng_valid  <= 1'b0;
        last_grant <= eng_src;
      end
      enable_count <= (nxt_st == ST_ARB) || (nxt_st == ST_SEND);
    end
  end

  // Saturating tally of engine-accepted orders per source
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (handshake) begin
      cnt[eng_src] <= sat_inc(cnt[eng_src]);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_flat
    assign accepted_count[g*COUNT_W +: COUNT_W] = cnt[g];
  end

endmodule

// File: tb/tb_order_arbiter.sv
// Randomized bench for order_arbiter: a session-level reference model
// predicts grants and tallies; a negedge monitor compares the DUT to it.
module tb_order_arbiter;

  localparam int N  = 4;
  localparam int OW = 32;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset, session_start, halt_in, eng_ready;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*OW-1:0] req_order;
  logic            eng_valid, enable_count;
  logic [OW-1:0]   eng_order;
  logic [SW-1:0]   eng_src;
  logic [N*8-1:0]  accepted_count;
  logic [1:0]      state;

  always #5 clk = ~clk;

  order_arbiter #(.NUM_REQ(N), .ORDER_W(OW), .SRC_W(SW)) dut (
    .clk            (clk),
    .reset          (reset),
    .session_start  (session_start),
    .halt_in        (halt_in),
    .req_valid      (req_valid),
    .req_order      (req_order),
    .req_ready      (req_ready),
    .eng_valid      (eng_valid),
    .eng_order      (eng_order),
    .eng_src        (eng_src),
    .eng_ready      (eng_ready),
    .enable_count   (enable_count),
    .accepted_count (accepted_count),
    .state          (state)
  );

  // Reference model: session phase, last served source, tallies
  typedef struct {
    int            src;
    logic [OW-1:0] ord;
  } exp_t;
  exp_t sbq[$];

  int  mstate;    // 0 closed, 1 open and waiting, 2 holding an order, 3 halted
  int  mlast;
  int  mcnt [N];
  int  held_src;
  bit  known = 1'b0;

  // Expected values for the cycle in progress
  bit             s_known = 1'b0;
  int             s_state;
  logic [N-1:0]   s_rr;
  logic           s_ev, s_en;
  logic [N*8-1:0] s_cnt;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic rst, input logic ss, input logic hl,
                     input logic [N-1:0] rv, input logic er);
    bit done;
    int s;
    @(posedge clk);
    #1;
    reset = rst; session_start = ss; halt_in = hl; req_valid = rv; eng_ready = er;
    for (int i = 0; i < N; i++) req_order[i*OW +: OW] = $urandom();
    s_known = known;
    s_state = mstate;
    s_rr    = '0;
    s_ev    = (mstate == 2);
    s_en    = (mstate == 1) || (mstate == 2);
    for (int i = 0; i < N; i++) s_cnt[i*8 +: 8] = 8'(mcnt[i]);
    if (rst) begin
      mstate = 0;
      mlast  = N - 1;
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      sbq.delete();
      known = 1'b1;
    end else if (known) begin
      case (mstate)
        0: if (ss) mstate = 1;
        1: begin
          if (hl) mstate = 3;
          else begin
            done = 1'b0;
            for (int k = 1; k <= N; k++) begin
              s = (mlast + k) % N;
              if (!done && rv[s]) begin
                done     = 1'b1;
                s_rr[s]  = 1'b1;
                held_src = s;
                sbq.push_back('{s, req_order[s*OW +: OW]});
                mstate   = 2;
              end
            end
          end
        end
        2: if (er) begin
          if (mcnt[held_src] < 255) mcnt[held_src]++;
          mlast  = held_src;
          mstate = hl ? 3 : 1;
        end
        default: ;
      endcase
    end
  endtask

  // Monitor: compare the DUT against the model away from the active edge
  always @(negedge clk) begin
    if (s_known) begin
      check("state", 64'(state), 64'(s_state));
      check("req_ready", 64'(req_ready), 64'(s_rr));
      check("eng_valid", 64'(eng_valid), 64'(s_ev));
      check("enable_count", 64'(enable_count), 64'(s_en));
      check("accepted_count", 64'(accepted_count), 64'(s_cnt));
      if (eng_valid && !reset) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard: eng_valid=1 with src %0d but no order expected", eng_src);
        end else begin
          check("eng_src", 64'(eng_src), 64'(sbq[0].src));
          check("eng_order", 64'(eng_order), 64'(sbq[0].ord));
          if (eng_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; session_start = 1'b0; halt_in = 1'b0;
    req_valid = '0; req_order = '0; eng_ready = 1'b0;

    // Reset, then a single order from source 0
    cyc(1, 0, 0, 4'b0000, 0);
    cyc(1, 0, 0, 4'b0000, 0);
    cyc(0, 0, 0, 4'b0000, 0);
    cyc(0, 1, 0, 4'b0000, 0);
    cyc(0, 0, 0, 4'b0001, 1);
    cyc(0, 0, 0, 4'b0000, 1);
    cyc(0, 0, 0, 4'b0000, 0);
    cyc(0, 0, 0, 4'b0000, 0);

    // All sources requesting: strict rotation
    repeat (16) cyc(0, 0, 0, 4'b1111, 1);

    // Stalled order while halt rises, then halted and start ignored
    cyc(0, 0, 0, 4'b0100, 0);
    cyc(0, 0, 0, 4'b0000, 0);
    cyc(0, 0, 0, 4'b0000, 0);
    repeat (3) cyc(0, 0, 1, 4'b1111, 0);
    cyc(0, 0, 1, 4'b1111, 1);
    repeat (4) cyc(0, 1, 0, 4'b1111, 1);

    // Halt in ARB with everyone requesting
    cyc(1, 0, 0, 4'b0000, 0);
    cyc(0, 1, 0, 4'b0000, 0);
    cyc(0, 0, 1, 4'b1111, 1);
    repeat (3) cyc(0, 1, 0, 4'b1111, 1);

    // Saturation of source 2's tally
    cyc(1, 0, 0, 4'b0000, 0);
    cyc(0, 1, 0, 4'b0000, 0);
    repeat (540) cyc(0, 0, 0, 4'b0100, 1);
    repeat (8) cyc(0, 0, 0, 4'b1011, 1);

    // Reset in the middle of SEND, then source 0 is first again
    repeat (3) cyc(0, 0, 0, 4'b1111, 0);
    cyc(1, 0, 0, 4'b1111, 0);
    cyc(0, 1, 0, 4'b1111, 1);
    repeat (4) cyc(0, 0, 0, 4'b1111, 1);

    // Random sessions
    for (int r = 0; r < 40; r++) begin
      cyc(1, 0, 0, 4'($urandom()), 1'($urandom()));
      cyc(0, 1, 0, 4'($urandom()), 1'($urandom()));
      for (int c = 0; c < 50; c++)
        cyc(($urandom_range(0, 60) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 40) == 0), 4'($urandom()), 1'($urandom()));
    end

    cyc(0, 0, 0, 4'b0000, 0);
    cyc(0, 0, 0, 4'b0000, 0);
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
